// File: rtl/march_c_sequencer.sv
// -----------------------------------------------------------------------------
// march_c_sequencer
//
// Generates the March C- stimulus for one memory: one operation per clock,
// 10 * 2^ADDR_WIDTH operations per run. The outputs drive the bist_in side of
// the MBIST input multiplexers (NbarT is their select), and expected_data
// goes to the downstream comparator.
//
// Elements, in order (up = address 0..N-1, down = address N-1..0):
//   E0 up (w0)  E1 up (r0,w1)  E2 up (r1,w0)
//   E3 dn (r0,w1)  E4 dn (r1,w0)  E5 dn (r0)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          begin a run; sampled only in IDLE or DONE
//   NbarT          1 during every run cycle (test mode), 0 otherwise
//   bist_addr      address of the current operation
//   bist_data      write data (background), valid when bist_we = 1
//   bist_we        write strobe
//   bist_re        read strobe
//   expected_data  expected read value (background), valid when bist_re = 1
//   done           high from completion until the next accepted start
// -----------------------------------------------------------------------------
module march_c_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  NbarT,
  output logic [ADDR_WIDTH-1:0] bist_addr,
  output logic [DATA_WIDTH-1:0] bist_data,
  output logic                  bist_we,
  output logic                  bist_re,
  output logic [DATA_WIDTH-1:0] expected_data,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_BOT  = '0;
  localparam logic [2:0]            ELEM_LAST = 3'd5;

  // The counters always describe the operation currently on the outputs,
  // so the successor logic below derives the next operation from them.
  state_e                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic                    phase_q, phase_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    nbar_t_q, nbar_t_d;
  logic                    we_q, we_d;
  logic                    re_q, re_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic                    done_q, done_d;

  // Successor of the current operation within a run.
  logic                    two_op, up_dir, last_addr, finish;
  logic [2:0]              succ_elem;
  logic                    succ_phase;
  logic [ADDR_WIDTH-1:0]   succ_addr;

  // Operation to present next cycle, and its decode.
  logic                    go;
  logic [2:0]              pres_elem;
  logic                    pres_phase;
  logic [ADDR_WIDTH-1:0]   pres_addr;
  logic                    op_write, op_one;
  logic [DATA_WIDTH-1:0]   background;

  always_comb begin
    two_op     = (elem_q != 3'd0) && (elem_q != ELEM_LAST);
    up_dir     = (elem_q < 3'd3);
    // Terminal address is compared explicitly rather than caught on wrap.
    last_addr  = up_dir ? (addr_q == ADDR_TOP) : (addr_q == ADDR_BOT);
    finish     = (elem_q == ELEM_LAST) && last_addr;

    succ_elem  = elem_q;
    succ_phase = 1'b0;
    succ_addr  = addr_q;
    if (two_op && !phase_q) begin
      // First op of a pair: same address, second op next.
      succ_phase = 1'b1;
    end else if (last_addr) begin
      succ_elem = elem_q + 3'd1;
      // E0..E2 run upward, E3..E5 downward; E2->E3 goes N-1 -> N-1.
      succ_addr = (elem_q < 3'd2) ? ADDR_BOT : ADDR_TOP;
    end else begin
      succ_addr = up_dir ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    elem_d     = 3'd0;
    phase_d    = 1'b0;
    addr_d     = '0;
    nbar_t_d   = 1'b0;
    we_d       = 1'b0;
    re_d       = 1'b0;
    data_d     = '0;
    exp_d      = '0;
    done_d     = 1'b0;
    go         = 1'b0;
    pres_elem  = 3'd0;
    pres_phase = 1'b0;
    pres_addr  = '0;

    unique case (state_q)
      RUN: begin
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          go         = 1'b1;
          pres_elem  = succ_elem;
          pres_phase = succ_phase;
          pres_addr  = succ_addr;
        end
      end
      default: begin  // IDLE, DONE
        if (start) begin
          state_d = RUN;
          go      = 1'b1;
        end else begin
          done_d = (state_q == DONE);
        end
      end
    endcase

    // Pairs are (r0,w1) in E1/E3 and (r1,w0) in E2/E4; E0 is w0, E5 is r0.
    unique case (pres_elem)
      3'd0:       begin op_write = 1'b1;       op_one = 1'b0;        end
      3'd1, 3'd3: begin op_write = pres_phase; op_one = pres_phase;  end
      3'd2, 3'd4: begin op_write = pres_phase; op_one = !pres_phase; end
      default:    begin op_write = 1'b0;       op_one = 1'b0;        end
    endcase
    background = op_one ? '1 : '0;

    if (go) begin
      elem_d   = pres_elem;
      phase_d  = pres_phase;
      addr_d   = pres_addr;
      nbar_t_d = 1'b1;
      we_d     = op_write;
      re_d     = !op_write;
      data_d   = op_write ? background : '0;
      exp_d    = op_write ? '0 : background;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      elem_q   <= 3'd0;
      phase_q  <= 1'b0;
      addr_q   <= '0;
      nbar_t_q <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      data_q   <= '0;
      exp_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      nbar_t_q <= nbar_t_d;
      we_q     <= we_d;
      re_q     <= re_d;
      data_q   <= data_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
    end
  end

  // The address counter is zero outside RUN, so it doubles as bist_addr.
  assign NbarT         = nbar_t_q;
  assign bist_addr     = addr_q;
  assign bist_data     = data_q;
  assign bist_we       = we_q;
  assign bist_re       = re_q;
  assign expected_data = exp_q;
  assign done          = done_q;

endmodule

// File: tb/tb_march_c_sequencer.sv
// -----------------------------------------------------------------------------
// tb_march_c_sequencer
//
// Two instances: A (ADDR_WIDTH=2, DATA_WIDTH=8, 40 run cycles) and
// B (ADDR_WIDTH=4, DATA_WIDTH=10, 160 run cycles). Expected sequences come
// from a March C- element table written as text ("r0w1" ...), plus a table
// of hand-computed operations for instance A.
// -----------------------------------------------------------------------------
module tb_march_c_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;

  logic       nbart_a, we_a, re_a, done_a;
  logic [1:0] addr_a;
  logic [7:0] data_a, exp_a;

  logic       nbart_b, we_b, re_b, done_b;
  logic [3:0] addr_b;
  logic [9:0] data_b, exp_b;

  march_c_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .NbarT(nbart_a),
    .bist_addr(addr_a), .bist_data(data_a), .bist_we(we_a), .bist_re(re_a),
    .expected_data(exp_a), .done(done_a)
  );

  march_c_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .NbarT(nbart_b),
    .bist_addr(addr_b), .bist_data(data_b), .bist_we(we_b), .bist_re(re_b),
    .expected_data(exp_b), .done(done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nbart; int we; int re; int addr; int data; int expd; int done;
  } obs_t;

  typedef struct {
    int we; int re; int addr; int data; int expd;
  } op_t;

  typedef struct {
    int cyc; int we; int addr; int val;
  } hand_t;

  int total = 0;
  int bad   = 0;
  op_t model_q[$];

  string march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};

  // Hand-computed operations for N=4, all-ones background 0xFF.
  hand_t hand [12] = '{
    '{1, 1, 0, 8'h00}, '{2, 1, 1, 8'h00}, '{3, 1, 2, 8'h00}, '{4, 1, 3, 8'h00},
    '{5, 0, 0, 8'h00}, '{6, 1, 0, 8'hFF}, '{21, 0, 3, 8'h00}, '{22, 1, 3, 8'hFF},
    '{37, 0, 3, 8'h00}, '{38, 0, 2, 8'h00}, '{39, 0, 1, 8'h00}, '{40, 0, 0, 8'h00}
  };

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.nbart = int'(nbart_b); o.we = int'(we_b); o.re = int'(re_b);
      o.addr = int'(addr_b); o.data = int'(data_b); o.expd = int'(exp_b);
      o.done = int'(done_b);
    end else begin
      o.nbart = int'(nbart_a); o.we = int'(we_a); o.re = int'(re_a);
      o.addr = int'(addr_a); o.data = int'(data_a); o.expd = int'(exp_a);
      o.done = int'(done_a);
    end
    return o;
  endfunction

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Expand the text element table into the per-cycle operation list.
  task automatic build_model(input int n, input int ones);
    model_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < n; k++) begin
        for (int p = 0; p < march[e].len() / 2; p++) begin
          op_t o;
          int  bg;
          bg     = (march[e][2*p+1] == "1") ? ones : 0;
          o.addr = (e < 3) ? k : n - 1 - k;
          o.we   = (march[e][2*p] == "w") ? 1 : 0;
          o.re   = 1 - o.we;
          o.data = o.we ? bg : 0;
          o.expd = o.we ? 0 : bg;
          model_q.push_back(o);
        end
      end
    end
  endtask

  task automatic check_quiet(input bit sel, input string tag, input int want_done);
    obs_t o;
    o = sample(sel);
    check({tag, " nbart"}, o.nbart, 0);
    check({tag, " we"},    o.we,    0);
    check({tag, " re"},    o.re,    0);
    check({tag, " addr"},  o.addr,  0);
    check({tag, " data"},  o.data,  0);
    check({tag, " exp"},   o.expd,  0);
    check({tag, " done"},  o.done,  want_done);
  endtask

  // Pulse start, follow a whole run plus three DONE cycles. With poke set,
  // start is pulsed again at run cycle 10 and must be ignored.
  task automatic run_seq(input bit sel, input int n, input bit poke, input string tag);
    obs_t  o;
    op_t   m;
    int    nb_cnt;
    string t;
    nb_cnt = 0;
    @(negedge clk); drive_start(sel, 1'b1);
    @(negedge clk); drive_start(sel, 1'b0);
    for (int cyc = 1; cyc <= 10 * n + 3; cyc++) begin
      if (cyc > 1) @(negedge clk);
      o = sample(sel);
      nb_cnt += o.nbart;
      t = $sformatf("%s c%0d", tag, cyc);
      if (cyc <= 10 * n) begin
        m = model_q[cyc-1];
        check({t, " nbart"}, o.nbart, 1);
        check({t, " done"},  o.done,  0);
        check({t, " we"},    o.we,    m.we);
        check({t, " re"},    o.re,    m.re);
        check({t, " addr"},  o.addr,  m.addr);
        check({t, " data"},  o.data,  m.data);
        check({t, " exp"},   o.expd,  m.expd);
        check({t, " we^re"}, o.we ^ o.re, 1);
        if (!sel) begin
          foreach (hand[i]) begin
            if (hand[i].cyc == cyc) begin
              check({t, " hand we"},   o.we,   hand[i].we);
              check({t, " hand addr"}, o.addr, hand[i].addr);
              check({t, " hand val"},  hand[i].we ? o.data : o.expd, hand[i].val);
            end
          end
        end
      end else begin
        check_quiet(sel, t, 1);
      end
      if (poke && cyc == 10) drive_start(sel, 1'b1);
      if (poke && cyc == 11) drive_start(sel, 1'b0);
    end
    check({tag, " run cycles"}, nb_cnt, 10 * n);
  endtask

  initial begin
    obs_t o;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #2 rst = 1'b1;
    #10;
    check_quiet(1'b0, "reset a", 0);
    check_quiet(1'b1, "reset b", 0);
    @(negedge clk); rst = 1'b0;

    build_model(4, 'hFF);
    run_seq(1'b0, 4, 1'b0, "a1");
    // Restart from DONE, with a start pulse during RUN that must be ignored.
    run_seq(1'b0, 4, 1'b1, "a2");

    // Asynchronous reset in the middle of run cycle 17.
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (16) @(negedge clk);
    o = sample(1'b0);
    check("midrst pre nbart", o.nbart, 1);
    #1 rst = 1'b1;
    #1 check_quiet(1'b0, "midrst", 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet(1'b0, "idle after rst", 0);
    end

    run_seq(1'b0, 4, 1'b0, "a3");

    build_model(16, 'h3FF);
    run_seq(1'b1, 16, 1'b0, "b1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/march_c_sequencer.md
Name: march_c_sequencer

Overview:
- Generates the March C- test stimulus for one memory: address, write data, write/read strobes and expected read data.
- Its `bist_addr`, `bist_data`, `bist_we` and `bist_re` outputs feed the `bist_in` side of the MBIST input multiplexers; its `NbarT` output drives their select.
- `expected_data` goes to the downstream comparator.
- One memory operation per clock; the whole algorithm runs in 10·2^ADDR_WIDTH cycles.

Parameters:
- ADDR_WIDTH, 4, memory address width; depth N = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, memory word width; background "0" = all zeros, "1" = all ones.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin test; sampled only in IDLE or DONE.
- NbarT  output  1  0 = normal mode, 1 = test mode (mux select).
- bist_addr  output  ADDR_WIDTH  memory address for the current operation.
- bist_data  output  DATA_WIDTH  write data; valid when bist_we=1.
- bist_we  output  1  write strobe, current cycle.
- bist_re  output  1  read strobe, current cycle.
- expected_data  output  DATA_WIDTH  expected read value; valid when bist_re=1.
- done  output  1  high from completion until the next accepted start.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-run):
  - state = IDLE.
  - All outputs = 0.
  - Element, phase and address counters = 0.
- States:
  - IDLE: start=1 → RUN, element 0, address 0. Otherwise stay.
  - RUN: present one operation per cycle, as listed below; start is ignored.
  - DONE: done=1 and all other outputs 0. start=1 → RUN, done drops on that edge. Otherwise stay.
- First operation appears on the outputs in the cycle after start is sampled; NbarT=1 in that same cycle.
- NbarT=1 for exactly the RUN cycles and 0 otherwise.
- March C- elements, executed in order. Per-address operation order is left to right; direction ⇑ = addr 0..N-1, ⇓ = addr N-1..0:
  - E0 ⇑ (w0)
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇓ (r0)
- Per-cycle output encoding:
  - Write op: bist_we=1, bist_re=0, bist_data = background, expected_data = 0.
  - Read op: bist_re=1, bist_we=0, expected_data = background, bist_data = 0.
  - bist_we and bist_re are never both 1.
- Two-operation elements: a phase bit toggles each cycle; the address advances only after the second operation.
- Element boundaries:
  - Last address of an element → next element's first address on the next cycle. No idle cycles between elements.
  - E2→E3 boundary: address jumps from N-1 to N-1 (E3 starts at top).
- Address wrap: address counter width is ADDR_WIDTH; the terminal address is detected explicitly, with no reliance on overflow.
- Completion: after the E5 read of address 0, the next cycle enters DONE.
  - NbarT, bist_re and bist_addr return to 0 in that cycle; done=1.
- Total RUN cycles = N + 4·2N + N = 10N.
- start held high continuously: one run per start acceptance. From DONE, a still-high start immediately restarts the test.

Test Plan:
- Reset → all outputs 0, NbarT=0, done=0. Assert rst mid-run (e.g. cycle 17) → all outputs 0 asynchronously, before the next clock edge; sequencer in IDLE.
- ADDR_WIDTH=2, DATA_WIDTH=8, pulse start one cycle:
  - Exactly 40 cycles with NbarT=1, then done=1.
  - Run cycles 1–4: we=1, addr 0,1,2,3, data 0x00.
  - Cycle 5: re=1, addr 0, expected 0x00.
  - Cycle 6: we=1, addr 0, data 0xFF.
- Same config, E3 start (run cycle 21): re=1, addr 3, expected 0x00. Cycle 22: we=1, addr 3, data 0xFF.
  - E5 (cycles 37–40): re=1, addr 3,2,1,0, expected 0x00.
- start pulsed during RUN (cycle 10) → no effect; the sequence matches the undisturbed run cycle for cycle.
- In DONE, pulse start → done=0 and NbarT=1 next cycle; a second full 40-cycle sequence, identical to the first.
- Every RUN cycle: assert (bist_we ^ bist_re)=1. Every non-RUN cycle: we=re=NbarT=0. Repeat with ADDR_WIDTH=4, DATA_WIDTH=10 → 160 run cycles, background 0x3FF.
